// File: rtl/branch_pred_ctrl_if.sv
// Decode / execute / table bundle for the
// 1-bit branch prediction controller.
interface branch_pred_ctrl_if #(
  parameter int IDXW = 6,
  parameter int CNTW = 16
);
  logic [IDXW-1:0] pc_d;
  logic            branch_d;
  logic            predict_taken_d;
  logic            stall_d;
  logic [IDXW-1:0] mem_raddr;
  logic            mem_rdata;
  logic [IDXW-1:0] mem_waddr;
  logic            mem_wd;
  logic            mem_we;
  logic            upd_valid_e;
  logic [IDXW-1:0] upd_idx_e;
  logic            upd_taken_e;
  logic            upd_pred_e;
  logic            mispredict_e;
  logic            clear_req;
  logic            busy;
  logic [CNTW-1:0] branch_count;
  logic [CNTW-1:0] miss_count;

  modport slave (
    input  pc_d, branch_d, mem_rdata,
    input  upd_valid_e, upd_idx_e,
    input  upd_taken_e, upd_pred_e,
    input  clear_req,
    output predict_taken_d, stall_d,
    output mem_raddr, mem_waddr,
    output mem_wd, mem_we,
    output mispredict_e, busy,
    output branch_count, miss_count
  );

  modport master (
    output pc_d, branch_d, mem_rdata,
    output upd_valid_e, upd_idx_e,
    output upd_taken_e, upd_pred_e,
    output clear_req,
    input  predict_taken_d, stall_d,
    input  mem_raddr, mem_waddr,
    input  mem_wd, mem_we,
    input  mispredict_e, busy,
    input  branch_count, miss_count
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// 1-bit BHT controller: clear sweep, write port
// ownership, same-cycle bypass and statistics.
module branch_pred_ctrl #(
  parameter int IDXW      = 6,
  parameter int DEPTH     = 32,
  parameter int MISS_ONLY = 1,
  parameter int CNTW      = 16
) (
  input  logic clk,
  input  logic reset,
  branch_pred_ctrl_if.slave bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [IDXW:0]   DEPTH_W = (IDXW+1)'(DEPTH);
  localparam logic [IDXW-1:0] LAST    = IDXW'(DEPTH - 1);

  state_t          state;
  logic [IDXW-1:0] clr_idx;
  logic            mis;
  logic            upd_ok;
  logic            pc_ok;
  logic            upd_we;

  // branch_d is informational only
  wire unused_branch_d = bus.branch_d;

  // clear sweep sequencer; clear_req restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (bus.clear_req) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      if (clr_idx == LAST) begin
        state   <= RUN;
        clr_idx <= '0;
      end else begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  // update qualification and write/predict muxing
  always_comb begin
    mis    = bus.upd_valid_e
           & (bus.upd_taken_e ^ bus.upd_pred_e);
    upd_ok = {1'b0, bus.upd_idx_e} < DEPTH_W;
    pc_ok  = {1'b0, bus.pc_d} < DEPTH_W;
    upd_we = bus.upd_valid_e & upd_ok
           & ~bus.clear_req
           & ((MISS_ONLY != 0) ? mis : 1'b1);
    bus.mem_we          = 1'b1;
    bus.mem_waddr       = clr_idx;
    bus.mem_wd          = 1'b0;
    bus.predict_taken_d = 1'b0;
    case (state)
      CLEAR: begin
        bus.mem_we    = 1'b1;
        bus.mem_waddr = clr_idx;
        bus.mem_wd    = 1'b0;
      end
      RUN: begin
        bus.mem_we    = upd_we;
        bus.mem_waddr = bus.upd_idx_e;
        bus.mem_wd    = bus.upd_taken_e;
        if (!pc_ok)
          bus.predict_taken_d = 1'b0;
        else if (upd_we
                 && bus.upd_idx_e == bus.pc_d)
          bus.predict_taken_d = bus.upd_taken_e;
        else
          bus.predict_taken_d = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.mispredict_e = mis;
  assign bus.mem_raddr    = bus.pc_d;
  assign bus.busy         = (state == CLEAR);
  assign bus.stall_d      = (state == CLEAR);

  // saturating statistics, live in both states
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.branch_count <= '0;
      bus.miss_count   <= '0;
    end else begin
      if (bus.upd_valid_e && bus.branch_count != '1)
        bus.branch_count <= bus.branch_count + 1'b1;
      if (mis && bus.miss_count != '1)
        bus.miss_count <= bus.miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl: sweep,
// bypass, out-of-range, clear restart, saturation.
module tb_branch_pred_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  branch_pred_ctrl_if #(.IDXW(6), .CNTW(16)) m();
  branch_pred_ctrl_if #(.IDXW(6), .CNTW(4))  s();

  branch_pred_ctrl #(
    .IDXW(6), .DEPTH(32),
    .MISS_ONLY(1), .CNTW(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(m.slave)
  );

  branch_pred_ctrl #(
    .IDXW(6), .DEPTH(32),
    .MISS_ONLY(1), .CNTW(4)
  ) dut_s (
    .clk(clk), .reset(reset), .bus(s.slave)
  );

  assign s.pc_d        = m.pc_d;
  assign s.branch_d    = m.branch_d;
  assign s.mem_rdata   = m.mem_rdata;
  assign s.upd_valid_e = m.upd_valid_e;
  assign s.upd_idx_e   = m.upd_idx_e;
  assign s.upd_taken_e = m.upd_taken_e;
  assign s.upd_pred_e  = m.upd_pred_e;
  assign s.clear_req   = m.clear_req;

  typedef struct {
    logic [5:0] pc;
    logic       rd;
    logic       v;
    logic [5:0] idx;
    logic       t;
    logic       p;
    logic       e_pt;
    logic       e_mis;
    logic       e_we;
    logic       e_wd;
  } vec_t;

  vec_t vecs [11];
  int checks = 0;
  int errors = 0;
  int nb = 0;
  int nm = 0;

  task automatic chk(input string nm_s,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm_s, act, exp);
    end
  endtask

  task automatic upd(input logic v,
                     input logic [5:0] idx,
                     input logic t, input logic p);
    m.upd_valid_e = v;
    m.upd_idx_e   = idx;
    m.upd_taken_e = t;
    m.upd_pred_e  = p;
  endtask

  task automatic tick_model();
    @(posedge clk);
    #1;
    if (m.upd_valid_e) nb++;
    if (m.upd_valid_e && (m.upd_taken_e ^ m.upd_pred_e))
      nm++;
  endtask

  task automatic sweep_check(input string tag);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c == 0 || c == 31) begin
        chk({tag, "_waddr"}, 32'(m.mem_waddr), c);
        chk({tag, "_we"}, 32'(m.mem_we), 1);
        chk({tag, "_busy"}, 32'(m.busy), 1);
      end else if (m.mem_waddr != 6'(c) || !m.busy) begin
        chk({tag, "_mid"}, 32'(m.mem_waddr), c);
      end
      tick_model();
    end
    chk({tag, "_done_busy"}, 32'(m.busy), 0);
    chk({tag, "_done_stall"}, 32'(m.stall_d), 0);
  endtask

  initial begin
    vecs[0]  = '{6'd0,  0, 1, 6'd5,  1, 0, 0, 1, 1, 1};
    vecs[1]  = '{6'd0,  0, 1, 6'd5,  1, 1, 0, 0, 0, 1};
    vecs[2]  = '{6'd9,  0, 1, 6'd9,  1, 0, 1, 1, 1, 1};
    vecs[3]  = '{6'd9,  0, 1, 6'd10, 1, 0, 0, 1, 1, 1};
    vecs[4]  = '{6'd9,  1, 0, 6'd0,  0, 0, 1, 0, 0, 0};
    vecs[5]  = '{6'd9,  1, 1, 6'd9,  0, 1, 0, 1, 1, 0};
    vecs[6]  = '{6'd9,  1, 1, 6'd9,  0, 0, 1, 0, 0, 0};
    vecs[7]  = '{6'd40, 1, 1, 6'd40, 1, 0, 0, 1, 0, 1};
    vecs[8]  = '{6'd31, 1, 1, 6'd31, 1, 0, 1, 1, 1, 1};
    vecs[9]  = '{6'd32, 1, 1, 6'd32, 0, 1, 0, 1, 0, 0};
    vecs[10] = '{6'd3,  0, 0, 6'd3,  1, 0, 0, 0, 0, 1};

    reset = 1'b1;
    m.pc_d = '0;
    m.branch_d = 1'b0;
    m.mem_rdata = 1'b0;
    m.clear_req = 1'b0;
    upd(0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_we", 32'(m.mem_we), 1);
    chk("rst_waddr", 32'(m.mem_waddr), 0);
    chk("rst_busy", 32'(m.busy), 1);
    chk("rst_bcnt", 32'(m.branch_count), 0);
    chk("rst_mcnt", 32'(m.miss_count), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("sw_wd", 32'(m.mem_wd), 0);
    chk("sw_pt", 32'(m.predict_taken_d), 0);
    chk("sw_stall", 32'(m.stall_d), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    sweep_check("init");

    for (int i = 0; i < 11; i++) begin
      m.pc_d = vecs[i].pc;
      m.mem_rdata = vecs[i].rd;
      upd(vecs[i].v, vecs[i].idx,
          vecs[i].t, vecs[i].p);
      @(negedge clk);
      chk($sformatf("v%0d_pt", i),
          32'(m.predict_taken_d), 32'(vecs[i].e_pt));
      chk($sformatf("v%0d_mis", i),
          32'(m.mispredict_e), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d_we", i),
          32'(m.mem_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we)
        chk($sformatf("v%0d_waddr", i),
            32'(m.mem_waddr), 32'(vecs[i].idx));
      chk($sformatf("v%0d_wd", i),
          32'(m.mem_wd), 32'(vecs[i].e_wd));
      chk($sformatf("v%0d_raddr", i),
          32'(m.mem_raddr), 32'(vecs[i].pc));
      tick_model();
      chk($sformatf("v%0d_bcnt", i),
          32'(m.branch_count), nb);
      chk($sformatf("v%0d_mcnt", i),
          32'(m.miss_count), nm);
    end

    m.pc_d = 6'd3;
    m.mem_rdata = 1'b0;
    m.clear_req = 1'b1;
    upd(1, 6'd3, 1, 0);
    @(negedge clk);
    chk("clr_drop_we", 32'(m.mem_we), 0);
    chk("clr_drop_pt", 32'(m.predict_taken_d), 0);
    chk("clr_mis", 32'(m.mispredict_e), 1);
    tick_model();
    m.clear_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) upd(1, 6'd5, 1, 0);
      else upd(0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("cs%0d_waddr", c),
          32'(m.mem_waddr), c);
      if (c == 3) begin
        chk("cs_upd_we", 32'(m.mem_we), 1);
        chk("cs_upd_wd", 32'(m.mem_wd), 0);
        chk("cs_upd_stall", 32'(m.stall_d), 1);
      end
      tick_model();
    end
    upd(0, 0, 0, 0);
    m.clear_req = 1'b1;
    @(negedge clk);
    chk("cs10_waddr", 32'(m.mem_waddr), 10);
    tick_model();
    m.clear_req = 1'b0;
    sweep_check("restart");
    chk("cs_bcnt", 32'(m.branch_count), nb);
    chk("cs_mcnt", 32'(m.miss_count), nm);

    upd(1, 6'd7, 1, 0);
    for (int k = 0; k < 20; k++) tick_model();
    upd(0, 0, 0, 0);
    chk("sat_mcnt16", 32'(m.miss_count), nm);
    chk("sat_mcnt4", 32'(s.miss_count),
        (nm > 15) ? 15 : nm);
    chk("sat_bcnt4", 32'(s.branch_count),
        (nb > 15) ? 15 : nb);

    m.clear_req = 1'b1;
    tick_model();
    m.clear_req = 1'b0;
    for (int k = 0; k < 5; k++) tick_model();
    @(negedge clk);
    #2;
    chk("pre_ar_waddr", 32'(m.mem_waddr), 5);
    reset = 1'b1;
    #1;
    chk("ar_waddr", 32'(m.mem_waddr), 0);
    chk("ar_we", 32'(m.mem_we), 1);
    chk("ar_busy", 32'(m.busy), 1);
    chk("ar_bcnt", 32'(m.branch_count), 0);
    chk("ar_mcnt", 32'(m.miss_count), 0);
    chk("ar_mcnt4", 32'(s.miss_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nb = 0;
    nm = 0;
    sweep_check("post_ar");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
- Controller for the 1-bit branch history table (DEPTH x 1b, async read, sync write).
- Sits between the decode/execute stages and the table.
- Sequences a clear sweep of the table after reset and on request, and owns the table write port.
- Forwards same-cycle execute updates to the decode prediction, flags mispredictions, and keeps branch/mispredict statistics.

Parameters:
IDXW, 6, index width of decode/execute table addresses
DEPTH, 32, number of implemented table entries (DEPTH <= 2**IDXW)
MISS_ONLY, 1, 1 = write table only on mispredict; 0 = write every valid update
CNTW, 16, width of statistics counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
pc_d  in  IDXW  decode-stage table index
branch_d  in  1  decode stage holds a branch
predict_taken_d  out  1  prediction for pc_d
stall_d  out  1  decode must hold (table clearing)
mem_raddr  out  IDXW  table read address (= pc_d)
mem_rdata  in  1  table read data (async)
mem_waddr  out  IDXW  table write address
mem_wd  out  1  table write data
mem_we  out  1  table write enable
upd_valid_e  in  1  execute stage resolved a branch
upd_idx_e  in  IDXW  index of resolved branch
upd_taken_e  in  1  actual outcome
upd_pred_e  in  1  prediction carried from decode
mispredict_e  out  1  resolved outcome != prediction
clear_req  in  1  request full table clear (pulse)
busy  out  1  clear sweep in progress
branch_count  out  CNTW  resolved branches
miss_count  out  CNTW  mispredictions

Behaviour:
- FSM states: CLEAR, RUN. Clear index register clr_idx, IDXW bits.
- Reset (async): state=CLEAR, clr_idx=0, branch_count=0, miss_count=0.
- CLEAR:
  - Outputs: mem_we=1, mem_waddr=clr_idx, mem_wd=0, busy=1, stall_d=1, predict_taken_d=0.
  - Each cycle clr_idx increments. When clr_idx==DEPTH-1, the next state is RUN and clr_idx returns to 0.
  - The sweep is exactly DEPTH cycles after reset release.
- clear_req:
  - In RUN: next state CLEAR with clr_idx=0.
  - In CLEAR: restart the sweep, clr_idx=0 next cycle.
  - Execute updates in the same cycle are dropped (table is being zeroed); counters still count.
- Execute updates during CLEAR are dropped; the sweep owns the write port.
- RUN:
  - busy=0, stall_d=0.
  - mem_we = upd_valid_e & (upd_idx_e < DEPTH) & (MISS_ONLY ? mispredict_e : 1).
  - mem_waddr=upd_idx_e, mem_wd=upd_taken_e.
- predict_taken_d (RUN):
  - If pc_d >= DEPTH: 0.
  - Else if mem_we and mem_waddr==pc_d: upd_taken_e (same-cycle bypass, write lands on the next edge).
  - Else: mem_rdata.
  - branch_d does not gate the prediction; it is informational only.
- mispredict_e = upd_valid_e & (upd_taken_e ^ upd_pred_e). It is combinational, valid in both states, and used by the pipeline for redirect.
- Counters:
  - branch_count increments when upd_valid_e.
  - miss_count increments when mispredict_e.
  - Both saturate at all-ones. They count in both states and are not cleared by clear_req.
- mem_raddr = pc_d always.
- Write outputs are combinational from state, clr_idx and execute inputs. While reset is asserted: mem_we=1, mem_waddr=0.
- Out-of-range update index (>= DEPTH): no write, still counted.

Test Plan:
- Reset release, DEPTH=32 -> mem_we=1 with mem_waddr 0..31 on consecutive cycles, mem_wd=0, busy=1 for 32 cycles; busy=0 and state RUN on cycle 33.
- RUN, MISS_ONLY=1, upd_valid_e=1 idx=5 taken=1 pred=0 -> mispredict_e=1, mem_we=1 waddr=5 wd=1, miss_count 0->1. Repeat with pred=1 -> mem_we=0, branch_count increments, miss_count unchanged.
- Bypass: pc_d=9, mem_rdata=0, same cycle upd idx=9 taken=1 pred=0 -> predict_taken_d=1. With idx=10 instead -> predict_taken_d=0.
- clear_req pulse in RUN -> next 32 cycles clear sweep from 0, stall_d=1. A second clear_req at sweep cycle 10 -> clr_idx returns to 0, and the sweep ends 32 cycles after the second pulse.
- Out-of-range: upd idx=40 mispredicted -> mem_we=0, miss_count increments. pc_d=40 -> predict_taken_d=0.
- Saturation (CNTW forced small, e.g. 4) -> 20 mispredicts leave miss_count=15. Async reset asserted mid-sweep -> state CLEAR, clr_idx=0, counters 0 immediately, without waiting for a clock edge.
